// File: rtl/seq_divider_16bit_pkg.sv
// Shared constants for the sequential 16-bit divider.
package seq_divider_16bit_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CntW  = 4;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

endpackage

// File: rtl/sub_16bit.sv
// Trial subtractor: diff = a - b, borrow set when b > a.
module sub_16bit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  // Extend by one bit so the MSB of the result is the borrow out.
  assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/seq_divider_16bit.sv
// Unsigned restoring divider, one quotient bit per clock, MSB first.
module seq_divider_16bit
  import seq_divider_16bit_pkg::*;
#(
  parameter int unsigned WIDTH = seq_divider_16bit_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  prem_q, prem_d;   // partial remainder
  logic [WIDTH-1:0]  dvd_q, dvd_d;     // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]  dsr_q, dsr_d;     // latched divisor
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic              done_q, done_d;
  logic              dbz_q, dbz_d;

  logic [WIDTH-1:0]  trial;
  logic [WIDTH-1:0]  diff;
  logic              borrow;
  logic              qbit;

  assign trial = {prem_q[WIDTH-2:0], dvd_q[WIDTH-1]};

  sub_16bit #(
    .WIDTH (WIDTH)
  ) u_sub (
    .a      (trial),
    .b      (dsr_q),
    .diff   (diff),
    .borrow (borrow)
  );

  // A set partial-remainder MSB means the true trial has a 17th bit and always
  // exceeds the divisor; the wrapped 16-bit difference is then still exact.
  assign qbit = prem_q[WIDTH-1] | ~borrow;

  // Next-state: operand load / divide-by-zero in idle, one shift-subtract step in run.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (divisor == '0) begin
            quo_d  = '1;
            rem_d  = dividend;
            dbz_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            dvd_d   = dividend;
            dsr_d   = divisor;
            prem_d  = '0;
            cnt_d   = CntW'(WIDTH - 1);
            dbz_d   = 1'b0;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        prem_d = qbit ? diff : trial;
        dvd_d  = {dvd_q[WIDTH-2:0], qbit};
        if (cnt_q == '0) begin
          quo_d   = dvd_d;
          rem_d   = prem_d;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign busy        = (state_q == StRun);
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/seq_divider_16bit.md
SEQ_DIVIDER_16BIT -- requirements
Module: seq_divider_16bit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width (only 16 is required to be supported).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request pulse; sampled only when not busy.
REQ-005 SHALL have port dividend  input  16  unsigned dividend; sampled with start.
REQ-006 SHALL have port divisor  input  16  unsigned divisor; sampled with start.
REQ-007 SHALL have port quotient  output  16  registered quotient.
REQ-008 SHALL have port remainder  output  16  registered remainder.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port div_by_zero  output  1  error flag for the last completed operation.

Function
REQ-012 SHALL perform unsigned restoring division, one quotient bit per cycle, MSB first.
REQ-013 SHALL use FSM states IDLE and RUN only; done is a registered pulse, not a state.
REQ-014 SHALL, in IDLE with start=1 and divisor!=0, latch both operands, clear the partial remainder, load iteration counter to 15, and enter RUN with busy=1 at that edge (the load edge).
REQ-015 SHALL, on each RUN edge, form trial = {partial_rem[14:0], dividend_msb}, subtract divisor; if there is no borrow, keep the difference and shift in quotient bit 1, otherwise keep trial and shift in 0.
REQ-016 SHALL, on the RUN edge where the counter is 0, write quotient and remainder, set done=1, set busy=0, and return to IDLE; done SHALL therefore be high in the cycle following the 16th edge after the load edge (17 edges total).
REQ-017 SHALL, in IDLE with start=1 and divisor==0, at that same edge set quotient=16'hFFFF, remainder=dividend, div_by_zero=1, done=1, and remain in IDLE with busy held 0.
REQ-018 SHALL clear div_by_zero on any accepted start whose divisor is nonzero.
REQ-019 SHALL ignore start while busy=1; the in-flight operands SHALL NOT change.
REQ-020 SHALL accept start in the same cycle that done is high (back-to-back operations).
REQ-021 SHALL hold quotient, remainder, and div_by_zero stable from done until the next completion.
REQ-022 SHALL deassert done after exactly one cycle unless another divide-by-zero start is accepted in that cycle.

Reset
REQ-023 SHALL, on rst=1 and independently of clk, force state=IDLE, quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, counter=0.
REQ-024 SHALL abandon any in-flight operation on reset; no done pulse SHALL follow.
REQ-025 SHALL accept start on the first rising edge after rst deasserts.

Structure
REQ-026 SHALL place WIDTH, counter width (4), and the state encodings (IDLE=1'b0, RUN=1'b1) in a shared constants package/header.
REQ-027 SHALL instantiate one sub-module, sub_16bit (a, b -> diff[15:0], borrow), for the trial subtraction; no other arithmetic operators SHALL be used in the datapath.

Verification
REQ-028 SHALL cover: 100/7 -> quotient=14, remainder=2, done on edge 17 after load, busy high for edges 1-16.
REQ-029 SHALL cover: 16'hFFFF/1 -> quotient=16'hFFFF, remainder=0; and 3/10 -> quotient=0, remainder=3.
REQ-030 SHALL cover: 5/0 -> done and div_by_zero high in the cycle after the start edge, quotient=16'hFFFF, remainder=5, busy never high.
REQ-031 SHALL cover: start with 50/5 pulsed at edge 5 of a running 100/7 -> result still 14 r 2, and no second done.
REQ-032 SHALL cover: start 1000/3 in the done cycle of 100/7 -> 14 r 2 is produced, then 333 r 1 follows 17 edges later.
REQ-033 SHALL cover: rst asserted mid-RUN between edges -> outputs 0 immediately, no done; a subsequent 9/4 -> 2 r 1.
